uart_cmd_decoder: RTL and testbench

Command decoder directly downstream of the UART receiver. It takes the receiver's byte/`avail` pair, synchronises it into the system clock domain, and assembles single- and multi-byte host commands. It drives the analyzer's configuration registers (trigger mask/value, sample divider, capture depth) and one-cycle control strobes (arm, abort, status request). Malformed, unknown or stalled commands are discarded with an error strobe.

---
 rtl/uart_cmd_decoder.sv | 176 +++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// Host command decoder behind the UART receiver: synchronises byte/avail,
// parses 1- and 3-byte commands, and drives analyzer config and control strobes.
module uart_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES  = 500000,
  parameter logic [15:0] DEFAULT_DIVIDER = 16'd1,
  parameter logic [15:0] DEFAULT_DEPTH   = 16'd1024
) (
  input  logic        i_clk,
  input  logic        _rst,
  input  logic [7:0]  i_data,
  input  logic        i_avail,
  output logic [7:0]  o_trig_mask,
  output logic [7:0]  o_trig_value,
  output logic [15:0] o_divider,
  output logic [15:0] o_depth,
  output logic        o_arm,
  output logic        o_abort,
  output logic        o_status_req,
  output logic        o_err,
  output logic        o_busy
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TIMEOUT_LIMIT = CW'(TIMEOUT_CYCLES);

  localparam logic [1:0] S_OP   = 2'd0;
  localparam logic [1:0] S_ARG0 = 2'd1;
  localparam logic [1:0] S_ARG1 = 2'd2;

  localparam logic [7:0] OP_ARM    = 8'h01;
  localparam logic [7:0] OP_ABORT  = 8'h02;
  localparam logic [7:0] OP_TRIG   = 8'h03;
  localparam logic [7:0] OP_DIV    = 8'h04;
  localparam logic [7:0] OP_DEPTH  = 8'h05;
  localparam logic [7:0] OP_STATUS = 8'h06;

  // sync_q[0..1] form the synchroniser, sync_q[2] is the edge-detect history.
  logic [2:0] sync_q;
  logic       strb_q;
  logic [7:0] byte_q;

  logic [1:0]    state_q, state_d;
  logic [7:0]    op_q, op_d;
  logic [7:0]    arg0_q, arg0_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    mask_q, mask_d;
  logic [7:0]    value_q, value_d;
  logic [15:0]   div_q, div_d;
  logic [15:0]   depth_q, depth_d;
  logic          arm_q, arm_d;
  logic          abort_q, abort_d;
  logic          status_q, status_d;
  logic          err_q, err_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would let sync_q ripple through in one cycle.
  always_ff @(posedge i_clk or negedge _rst) begin
    if (!_rst) begin
      sync_q <= 3'b000;
      strb_q <= 1'b0;
      byte_q <= 8'h00;
    end else begin
      sync_q <= {sync_q[1:0], i_avail};
      strb_q <= sync_q[1] & ~sync_q[2];
      if (sync_q[1] & ~sync_q[2]) byte_q <= i_data;
    end
  end

  // NOTE: every next-state signal is defaulted first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    arg0_d   = arg0_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    value_d  = value_q;
    div_d    = div_q;
    depth_d  = depth_q;
    arm_d    = 1'b0;
    abort_d  = 1'b0;
    status_d = 1'b0;
    err_d    = 1'b0;

    if (strb_q) begin
      cnt_d = '0;
      case (state_q)
        S_OP: begin
          case (byte_q)
            OP_ARM:    arm_d    = 1'b1;
            OP_ABORT:  abort_d  = 1'b1;
            OP_STATUS: status_d = 1'b1;
            OP_TRIG, OP_DIV, OP_DEPTH: begin
              op_d    = byte_q;
              state_d = S_ARG0;
            end
            default:   err_d    = 1'b1;
          endcase
        end
        S_ARG0: begin
          arg0_d  = byte_q;
          state_d = S_ARG1;
        end
        S_ARG1: begin
          state_d = S_OP;
          case (op_q)
            OP_TRIG: begin
              mask_d  = arg0_q;
              value_d = byte_q;
            end
            OP_DIV: begin
              if ({byte_q, arg0_q} == 16'h0000) err_d = 1'b1;
              else                              div_d = {byte_q, arg0_q};
            end
            OP_DEPTH: depth_d = {byte_q, arg0_q};
            default:  err_d   = 1'b1;
          endcase
        end
        default: state_d = S_OP;
      endcase
    end else if (state_q != S_OP) begin
      // A stalled host loses its partial command; the byte strobe above takes priority.
      if (cnt_q == TIMEOUT_LIMIT) begin
        err_d   = 1'b1;
        state_d = S_OP;
        op_d    = 8'h00;
        arg0_d  = 8'h00;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge _rst) begin
    if (!_rst) begin
      state_q  <= S_OP;
      op_q     <= 8'h00;
      arg0_q   <= 8'h00;
      cnt_q    <= '0;
      mask_q   <= 8'h00;
      value_q  <= 8'h00;
      div_q    <= DEFAULT_DIVIDER;
      depth_q  <= DEFAULT_DEPTH;
      arm_q    <= 1'b0;
      abort_q  <= 1'b0;
      status_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      arg0_q   <= arg0_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      value_q  <= value_d;
      div_q    <= div_d;
      depth_q  <= depth_d;
      arm_q    <= arm_d;
      abort_q  <= abort_d;
      status_q <= status_d;
      err_q    <= err_d;
    end
  end

  assign o_trig_mask  = mask_q;
  assign o_trig_value = value_q;
  assign o_divider    = div_q;
  assign o_depth      = depth_q;
  assign o_arm        = arm_q;
  assign o_abort      = abort_q;
  assign o_status_req = status_q;
  assign o_err        = err_q;
  assign o_busy       = (state_q != S_OP);

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: stimulus pushes expected events,
// a negedge monitor pops and compares whenever a strobe fires or config changes.
module tb_uart_cmd_decoder;

  localparam int unsigned TO = 100;

  localparam logic [2:0] K_ARM = 3'd1, K_ABORT = 3'd2, K_STATUS = 3'd3,
                         K_ERR = 3'd4, K_CFG = 3'd5;

  typedef struct packed {
    logic [2:0]  kind;
    logic [7:0]  mask;
    logic [7:0]  value;
    logic [15:0] div;
    logic [15:0] depth;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        avail = 1'b0;
  logic [7:0]  trig_mask, trig_value;
  logic [15:0] divider, depth;
  logic        arm, abort_s, status_req, err, busy;

  int n_checks = 0;
  int n_fail   = 0;

  ev_t exp_q[$];
  logic [7:0]  m_mask  = 8'h00;
  logic [7:0]  m_value = 8'h00;
  logic [15:0] m_div   = 16'd1;
  logic [15:0] m_depth = 16'd1024;

  uart_cmd_decoder #(
    .TIMEOUT_CYCLES (TO),
    .DEFAULT_DIVIDER(16'd1),
    .DEFAULT_DEPTH  (16'd1024)
  ) dut (
    .i_clk       (clk),
    ._rst        (rst_n),
    .i_data      (data),
    .i_avail     (avail),
    .o_trig_mask (trig_mask),
    .o_trig_value(trig_value),
    .o_divider   (divider),
    .o_depth     (depth),
    .o_arm       (arm),
    .o_abort     (abort_s),
    .o_status_req(status_req),
    .o_err       (err),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_ev(input logic [2:0] kind);
    ev_t e;
    e.kind  = kind;
    e.mask  = m_mask;
    e.value = m_value;
    e.div   = m_div;
    e.depth = m_depth;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    data  = b;
    avail = 1'b1;
    repeat (4) @(negedge clk);
    avail = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mask"},  64'(trig_mask),  64'h00);
    check({tag, "_value"}, 64'(trig_value), 64'h00);
    check({tag, "_div"},   64'(divider),    64'd1);
    check({tag, "_depth"}, 64'(depth),      64'd1024);
    check({tag, "_strobes_busy"}, 64'({arm, abort_s, status_req, err, busy}), 64'h0);
  endtask

  // Monitor: any strobe or config change is one observable event.
  logic [47:0] prev_cfg;
  initial prev_cfg = {8'h00, 8'h00, 16'd1, 16'd1024};

  always @(negedge clk) begin
    logic [3:0]  strobes;
    logic [47:0] cur_cfg;
    ev_t obs, e;
    strobes = {arm, abort_s, status_req, err};
    cur_cfg = {trig_mask, trig_value, divider, depth};
    if (!rst_n) begin
      prev_cfg = cur_cfg;
    end else if (strobes != 4'b0000 || cur_cfg != prev_cfg) begin
      if (strobes != 4'b0000) check("strobe_onehot", 64'($countones(strobes)), 64'd1);
      obs.kind = arm ? K_ARM : abort_s ? K_ABORT : status_req ? K_STATUS : err ? K_ERR : K_CFG;
      {obs.mask, obs.value, obs.div, obs.depth} = cur_cfg;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got %h, expected none (t=%0t)", obs, $time);
      end else begin
        e = exp_q.pop_front();
        check("event", 64'(obs), 64'(e));
      end
      prev_cfg = cur_cfg;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // ARM with exact latency: pulse visible only between E3 and E4.
    expect_ev(K_ARM);
    @(negedge clk);
    data  = 8'h01;
    avail = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("arm_before_E3", 64'(arm), 64'd0);
    @(posedge clk);
    #1 check("arm_at_E3", 64'(arm), 64'd1);
    check("busy_after_arm", 64'(busy), 64'd0);
    @(posedge clk);
    #1 check("arm_after_E4", 64'(arm), 64'd0);
    @(negedge clk);
    avail = 1'b0;
    repeat (4) @(negedge clk);

    expect_ev(K_ABORT);
    send_byte(8'h02);

    // TRIG: busy through the args, both registers update together.
    send_byte(8'h03);
    check("busy_trig_op", 64'(busy), 64'd1);
    send_byte(8'hF0);
    check("busy_trig_arg0", 64'(busy), 64'd1);
    m_mask  = 8'hF0;
    m_value = 8'h5A;
    expect_ev(K_CFG);
    send_byte(8'h5A);
    check("busy_trig_done", 64'(busy), 64'd0);

    // DIV of zero is rejected, then a real value lands.
    send_byte(8'h04);
    send_byte(8'h00);
    expect_ev(K_ERR);
    send_byte(8'h00);
    send_byte(8'h04);
    send_byte(8'h34);
    m_div = 16'h1234;
    expect_ev(K_CFG);
    send_byte(8'h12);

    // DEPTH stalls after one argument and times out.
    send_byte(8'h05);
    send_byte(8'h10);
    check("busy_before_timeout", 64'(busy), 64'd1);
    expect_ev(K_ERR);
    repeat (TO + 10) @(negedge clk);
    check("busy_after_timeout", 64'(busy), 64'd0);
    expect_ev(K_STATUS);
    send_byte(8'h06);

    // DEPTH of zero is legal.
    send_byte(8'h05);
    send_byte(8'h00);
    m_depth = 16'h0000;
    expect_ev(K_CFG);
    send_byte(8'h00);

    // Unknown opcode held high for 1000 cycles strobes once.
    expect_ev(K_ERR);
    @(negedge clk);
    data  = 8'h7E;
    avail = 1'b1;
    repeat (1000) @(negedge clk);
    avail = 1'b0;
    repeat (4) @(negedge clk);

    // Reset mid-command: everything back to defaults at once.
    send_byte(8'h03);
    check("busy_before_reset", 64'(busy), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_values("midcmd_reset");
    m_mask  = 8'h00;
    m_value = 8'h00;
    m_div   = 16'd1;
    m_depth = 16'd1024;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    expect_ev(K_ERR);
    send_byte(8'hAA);
    check("trig_untouched", 64'({trig_mask, trig_value}), 64'h0000);

    repeat (10) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
